burst_mem: RTL and testbench
============================

Name: burst_mem

Overview:
- Single-port, parametrised word memory for the accelerator's weight/activation storage.
- Successor to the fixed single-word, shared-bus memory. Adds:
  - separate read and write data paths
  - valid/ready request handshake
  - multi-beat bursts with address wrap-around
  - per-byte write strobes
  - programmable access latency
- Sits between the convolution datapath controller and local storage; one outstanding request at a time.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDRESS_WIDTH, 8, word address width; depth = 2**ADDRESS_WIDTH.
- LATENCY, 2, wait cycles between request accept and first data beat; legal range 0..15.
- MAX_BURST, 8, maximum beats per request; must be ≥1.
- (localparam) BLEN_W = $clog2(MAX_BURST+1); STRB_W = DATA_WIDTH/8.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request
- req_write  input  1  1=write burst, 0=read burst
- req_addr  input  ADDRESS_WIDTH  start word address
- req_len  input  BLEN_W  beat count
- wdata  input  DATA_WIDTH  write beat data
- wstrb  input  STRB_W  byte enables for wdata
- wvalid  input  1  write beat present
- wready  output  1  write beat accepted this cycle when wvalid=1
- rdata  output  DATA_WIDTH  read beat data (registered)
- rvalid  output  1  rdata valid
- rlast  output  1  final read beat
- done  output  1  one-cycle pulse at request completion
- busy  output  1  request in progress (state != IDLE)

Behaviour:
- Reset (rst=0, async):
  - state=IDLE.
  - req_ready=1; wready, rdata, rvalid, rlast, done and busy all 0.
  - Memory contents are not cleared.
- Reset mid-burst: aborts immediately. Beats already written are retained; no done pulse.
- States: IDLE, WAIT, RD, WR, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: latch addr, write and length; effective length = req_len clamped to 1..MAX_BURST (0→1, >MAX_BURST→MAX_BURST).
  - Next state: WAIT if LATENCY>0, else RD/WR.
- WAIT: counts exactly LATENCY cycles, then RD or WR per latched req_write. req_ready=0 in all states except IDLE.
- RD:
  - Each cycle registers rdata<=mem[addr], rvalid<=1, addr<=addr+1, beats decrement.
  - rlast=1 with the final beat. Next state: DONE.
  - No backpressure: the consumer must take every beat.
  - Timing: accept on edge E0 → first rvalid high after edge E0+LATENCY+1. Beats are back-to-back.
- WR:
  - wready=1.
  - On wvalid: write byte lane i of mem[addr] only where wstrb[i]=1; addr++, beats decrement.
  - Idle wvalid=0 cycles are allowed (no timeout).
  - After the last beat accepted: wready=0 and go to DONE.
- DONE: done=1 for exactly one cycle; rvalid and rlast return to 0; next state IDLE.
- Address wrap: addr increments modulo 2**ADDRESS_WIDTH, so a burst at 0xFE of length 4 touches FE, FF, 00, 01.
- Ignored inputs:
  - wvalid is ignored outside WR.
  - req_valid is ignored while busy.
  - A request presented on the DONE cycle is held until IDLE.
- Read-after-write: a read issued after a write's done returns the new data.

Optional Feature:
- Macro: BURST_MEM_ACCESS_CNT_EN.
- Defined:
  - Adds output ports rd_beats and wr_beats, each 32 bits, reset to 0.
  - Each increments by 1 per read beat issued / write beat accepted.
  - Each saturates at 0xFFFFFFFF.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Package burst_mem_pkg:
  - state enum (IDLE, WAIT, RD, WR, DONE)
  - length clamp function
  - LATENCY range check constant
- One natural sub-module: burst_mem_array, the storage array with byte-strobed synchronous write and registered read. burst_mem holds the FSM, counters and handshake.

Test Plan:
- Write then read, LATENCY=2: write addr 0x10, len 4, data 0xA0..0xA3, wstrb=0xF → done after the 4th beat. Read same → rvalid first high 3 cycles after accept, beats 0xA0..0xA3 consecutive, rlast on 0xA3, done next cycle.
- Byte strobes: write 0x11223344 to addr 5; write 0xFFFFFFFF with wstrb=0b0101 → read returns 0x11FF33FF.
- Wrap and clamp: write len 0 at 0xFF → exactly 1 beat. Read len 3 at 0xFF → beats from FF, 00, 01. req_len=12 with MAX_BURST=8 → exactly 8 beats.
- Handshake stalls: during a write burst drop wvalid for 3 cycles → wready stays 1, no write occurs, burst completes after beats resume. A req_valid during the burst → req_ready=0 until IDLE, then accepted.
- Reset mid-burst: assert rst=0 after 2 of 4 write beats → outputs zero immediately, no done. Read shows 2 beats written, 2 unchanged.
- LATENCY=0 build: read accept on edge E0 → rvalid high after E0+1. With BURST_MEM_ACCESS_CNT_EN: rd_beats=3 after a len-3 read.

Source files
------------

// File: rtl/burst_mem_pkg.sv
// Shared types and helpers for burst_mem: FSM state encoding, burst-length
// clamp and the access-latency bound.
package burst_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    RD,
    WR,
    DONE
  } state_t;

  // Largest legal access latency; also sizes the wait counter.
  localparam int LATENCY_MAX = 15;
  localparam int LAT_W       = 4;

  // A zero-length request still moves one beat; oversize requests are cut to the maximum.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_burst);
    if (len == 0) begin
      return 1;
    end else if (len > max_burst) begin
      return max_burst;
    end else begin
      return len;
    end
  endfunction

endpackage

// File: rtl/burst_mem_if.sv
// Request, write-beat and read-beat signals between the datapath controller
// (master) and burst_mem (slave).
interface burst_mem_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 8,
  parameter int MAX_BURST     = 8
);
  localparam int BLEN_W = $clog2(MAX_BURST + 1);
  localparam int STRB_W = DATA_WIDTH / 8;

  logic                     req_valid;
  logic                     req_ready;
  logic                     req_write;
  logic [ADDRESS_WIDTH-1:0] req_addr;
  logic [BLEN_W-1:0]        req_len;
  logic [DATA_WIDTH-1:0]    wdata;
  logic [STRB_W-1:0]        wstrb;
  logic                     wvalid;
  logic                     wready;
  logic [DATA_WIDTH-1:0]    rdata;
  logic                     rvalid;
  logic                     rlast;
  logic                     done;
  logic                     busy;

  modport master (
    output req_valid, req_write, req_addr, req_len, wdata, wstrb, wvalid,
    input  req_ready, wready, rdata, rvalid, rlast, done, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_len, wdata, wstrb, wvalid,
    output req_ready, wready, rdata, rvalid, rlast, done, busy
  );

endinterface

// File: rtl/burst_mem_array.sv
// burst_mem_array: 2**ADDRESS_WIDTH x DATA_WIDTH storage, byte-strobed synchronous write, registered read.
// Latency: write lands on the clock edge; read data appears one cycle after re.
// Backpressure: none; one access per cycle on the shared address.
module burst_mem_array
  import burst_mem_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDRESS_WIDTH-1:0]   addr,
  input  logic                       we,
  input  logic [DATA_WIDTH-1:0]      wdata,
  input  logic [DATA_WIDTH/8-1:0]    wstrb,
  input  logic                       re,
  output logic [DATA_WIDTH-1:0]      rdata
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int DEPTH  = 2 ** ADDRESS_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Contents survive reset, so the array itself has no reset term.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wstrb[i]) begin
          mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/burst_mem.sv
// burst_mem: single-port burst memory, valid/ready requests, strobed writes, wrapping addresses; BURST_MEM_ACCESS_CNT_EN adds beat counters.
// Latency: first read beat LATENCY+1 cycles after accept, beats back-to-back; done pulses the cycle after the final beat.
// Backpressure: req_ready only while idle; write beats paced by wvalid; reads cannot be stalled.
module burst_mem
  import burst_mem_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 8,
  parameter int LATENCY       = 2,
  parameter int MAX_BURST     = 8
) (
  input  logic        clk,
  input  logic        rst,
  burst_mem_if.slave  bus
`ifdef BURST_MEM_ACCESS_CNT_EN
  ,
  output logic [31:0] rd_beats,
  output logic [31:0] wr_beats
`endif
);
  localparam int BLEN_W = $clog2(MAX_BURST + 1);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam logic [LAT_W-1:0] LAT_LAST = (LATENCY > 0) ? LAT_W'(LATENCY - 1) : '0;

  if (LATENCY < 0 || LATENCY > LATENCY_MAX) begin : g_bad_latency
    $error("burst_mem: LATENCY must lie in 0..15");
  end
  if (DATA_WIDTH % 8 != 0) begin : g_bad_width
    $error("burst_mem: DATA_WIDTH must be a multiple of 8");
  end
  if (MAX_BURST < 1) begin : g_bad_burst
    $error("burst_mem: MAX_BURST must be at least 1");
  end

  state_t                   state;
  state_t                   state_nxt;
  logic [ADDRESS_WIDTH-1:0] addr;
  logic [BLEN_W-1:0]        beats;
  logic                     write_q;
  logic [LAT_W-1:0]         wait_cnt;
  logic                     rvalid_q;
  logic                     rlast_q;
  logic                     done_q;
  logic [DATA_WIDTH-1:0]    rdata_w;

  logic accept;
  logic rd_beat;
  logic wr_beat;
  logic last_beat;

  assign accept    = bus.req_valid && (state == IDLE);
  assign rd_beat   = (state == RD);
  assign wr_beat   = (state == WR) && bus.wvalid;
  assign last_beat = (beats == BLEN_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (LATENCY > 0) begin
            state_nxt = WAIT;
          end else begin
            state_nxt = bus.req_write ? WR : RD;
          end
        end
      end
      WAIT: begin
        if (wait_cnt == LAT_LAST) begin
          state_nxt = write_q ? WR : RD;
        end
      end
      RD: begin
        if (last_beat) begin
          state_nxt = DONE;
        end
      end
      WR: begin
        if (bus.wvalid && last_beat) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read strobes and done are registered, so each trails its state by one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr     <= '0;
      beats    <= '0;
      write_q  <= 1'b0;
      wait_cnt <= '0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      done_q   <= (state == DONE);
      if (accept) begin
        addr     <= bus.req_addr;
        write_q  <= bus.req_write;
        beats    <= BLEN_W'(clamp_len(int'(bus.req_len), int'(MAX_BURST)));
        wait_cnt <= '0;
      end
      if (state == WAIT) begin
        wait_cnt <= wait_cnt + LAT_W'(1);
      end
      if (rd_beat || wr_beat) begin
        addr  <= addr + ADDRESS_WIDTH'(1);
        beats <= beats - BLEN_W'(1);
      end
      if (rd_beat) begin
        rvalid_q <= 1'b1;
        rlast_q  <= last_beat;
      end
    end
  end

  burst_mem_array #(
    .DATA_WIDTH    (DATA_WIDTH),
    .ADDRESS_WIDTH (ADDRESS_WIDTH)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .addr  (addr),
    .we    (wr_beat),
    .wdata (bus.wdata),
    .wstrb (bus.wstrb),
    .re    (rd_beat),
    .rdata (rdata_w)
  );

  assign bus.req_ready = (state == IDLE);
  assign bus.wready    = (state == WR);
  assign bus.busy      = (state != IDLE);
  assign bus.rdata     = rdata_w;
  assign bus.rvalid    = rvalid_q;
  assign bus.rlast     = rlast_q;
  assign bus.done      = done_q;

`ifdef BURST_MEM_ACCESS_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_beats <= '0;
      wr_beats <= '0;
    end else begin
      if (rd_beat && (rd_beats != '1)) begin
        rd_beats <= rd_beats + 32'd1;
      end
      if (wr_beat && (wr_beats != '1)) begin
        wr_beats <= wr_beats + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_burst_mem.sv
// Directed bench for burst_mem: one LATENCY=2 instance and one LATENCY=0 instance
// sharing stimulus, selected by sel.
module tb_burst_mem;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int MB = 8;
  localparam int BW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          sel;
  logic          req_valid;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [BW-1:0] req_len;
  logic [DW-1:0] wdata;
  logic [3:0]    wstrb;
  logic          wvalid;

  burst_mem_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MAX_BURST(MB)) b2 ();
  burst_mem_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MAX_BURST(MB)) b0 ();

  assign b2.req_valid = req_valid && !sel;
  assign b2.req_write = req_write;
  assign b2.req_addr  = req_addr;
  assign b2.req_len   = req_len;
  assign b2.wdata     = wdata;
  assign b2.wstrb     = wstrb;
  assign b2.wvalid    = wvalid && !sel;
  assign b0.req_valid = req_valid && sel;
  assign b0.req_write = req_write;
  assign b0.req_addr  = req_addr;
  assign b0.req_len   = req_len;
  assign b0.wdata     = wdata;
  assign b0.wstrb     = wstrb;
  assign b0.wvalid    = wvalid && sel;

  wire          s_req_ready = sel ? b0.req_ready : b2.req_ready;
  wire          s_wready    = sel ? b0.wready    : b2.wready;
  wire [DW-1:0] s_rdata     = sel ? b0.rdata     : b2.rdata;
  wire          s_rvalid    = sel ? b0.rvalid    : b2.rvalid;
  wire          s_rlast     = sel ? b0.rlast     : b2.rlast;
  wire          s_done      = sel ? b0.done      : b2.done;
  wire          s_busy      = sel ? b0.busy      : b2.busy;

`ifdef BURST_MEM_ACCESS_CNT_EN
  logic [31:0] rd_beats2, wr_beats2, rd_beats0, wr_beats0;
`endif

  burst_mem #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .LATENCY(2), .MAX_BURST(MB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b2)
`ifdef BURST_MEM_ACCESS_CNT_EN
    ,
    .rd_beats (rd_beats2),
    .wr_beats (wr_beats2)
`endif
  );

  burst_mem #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .LATENCY(0), .MAX_BURST(MB)) dut_lat0 (
    .clk (clk),
    .rst (rst),
    .bus (b0)
`ifdef BURST_MEM_ACCESS_CNT_EN
    ,
    .rd_beats (rd_beats0),
    .wr_beats (wr_beats0)
`endif
  );

  int checks = 0;
  int errors = 0;
  int exp_rd = 0;
  int exp_wr = 0;

  logic [31:0] rbuf [16];
  int rn, first_lat, last_idx, rlast_cnt, done_at;
  logic stall_ok;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_wready(input string tag);
    int k;
    k = 0;
    while (!s_wready && k < 20) begin
      step();
      k++;
    end
    check(tag, 32'(s_wready), 32'd1);
  endtask

  task automatic drive_beat(input logic [31:0] d, input logic [3:0] s);
    wvalid = 1'b1;
    wdata  = d;
    wstrb  = s;
    if (s_wready && !sel) exp_wr++;
    step();
    wvalid = 1'b0;
  endtask

  task automatic wr_burst(input logic [7:0] a, input logic [3:0] len, input logic [31:0] base,
                          input logic [3:0] s, input int n, input string tag);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = a;
    req_len   = len;
    step();
    req_valid = 1'b0;
    wait_wready({tag, "_wready"});
    for (int i = 0; i < n; i++) drive_beat(base + 32'(i), s);
    check({tag, "_wready_end"}, 32'(s_wready), 32'd0);
    step();
    check({tag, "_done"}, 32'(s_done), 32'd1);
  endtask

  // First step is the accept edge; k counts cycles after it.
  task automatic rd_collect(input string tag);
    rn = 0; first_lat = -1; last_idx = -1; rlast_cnt = 0; done_at = -1;
    step();
    req_valid = 1'b0;
    for (int k = 1; k <= 40 && done_at < 0; k++) begin
      step();
      if (s_rvalid) begin
        if (first_lat < 0) first_lat = k;
        if (rn < 16) rbuf[rn] = s_rdata;
        if (s_rlast) begin
          last_idx = rn;
          rlast_cnt++;
        end
        rn++;
        if (!sel) exp_rd++;
      end
      if (s_done) done_at = k;
    end
    check({tag, "_done_seen"}, 32'(done_at >= 0), 32'd1);
  endtask

  task automatic rd_burst(input logic [7:0] a, input logic [3:0] len, input string tag);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = a;
    req_len   = len;
    rd_collect(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
    wdata = '0; wstrb = '0; wvalid = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(s_req_ready), 32'd1);
    check("rst_wready",    32'(s_wready),    32'd0);
    check("rst_rdata",     s_rdata,          32'd0);
    check("rst_rvalid",    32'(s_rvalid),    32'd0);
    check("rst_rlast",     32'(s_rlast),     32'd0);
    check("rst_done",      32'(s_done),      32'd0);
    check("rst_busy",      32'(s_busy),      32'd0);
    rst = 1'b1;
    step();

    // Write then read, LATENCY=2
    wr_burst(8'h10, 4'd4, 32'hA0, 4'hF, 4, "wr10");
    rd_burst(8'h10, 4'd4, "rd10");
    check("rd10_beats", rn, 4);
    check("rd10_first_lat", first_lat, 3);
    for (int i = 0; i < 4; i++) check("rd10_data", rbuf[i], 32'hA0 + 32'(i));
    check("rd10_rlast_idx", last_idx, 3);
    check("rd10_rlast_cnt", rlast_cnt, 1);
    check("rd10_done_at", done_at, 7);

    // Byte strobes
    wr_burst(8'h05, 4'd1, 32'h11223344, 4'hF, 1, "wr5a");
    wr_burst(8'h05, 4'd1, 32'hFFFFFFFF, 4'b0101, 1, "wr5b");
    rd_burst(8'h05, 4'd1, "rd5");
    check("strobe_data", rbuf[0], 32'h11FF33FF);

    // Wrap and clamp
    wr_burst(8'hFE, 4'd4, 32'hB0, 4'hF, 4, "wrFE");
    wr_burst(8'hFF, 4'd0, 32'hC0, 4'hF, 1, "wrlen0");
    rd_burst(8'hFF, 4'd3, "rdwrap");
    check("wrap_beats", rn, 3);
    check("wrap_ff", rbuf[0], 32'hC0);
    check("wrap_00", rbuf[1], 32'hB2);
    check("wrap_01", rbuf[2], 32'hB3);
    wr_burst(8'h28, 4'd1, 32'h55, 4'hF, 1, "wr28");
    wr_burst(8'h20, 4'd12, 32'hD0, 4'hF, 8, "wrlen12");
    rd_burst(8'h20, 4'd12, "rdlen12");
    check("clamp_beats", rn, 8);
    check("clamp_first", rbuf[0], 32'hD0);
    check("clamp_last", rbuf[7], 32'hD7);
    check("clamp_rlast_idx", last_idx, 7);
    rd_burst(8'h28, 4'd1, "rd28");
    check("clamp_no_ninth", rbuf[0], 32'h55);

    // Handshake stalls with a read request held during the write burst
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h30; req_len = 4'd4;
    step();
    req_write = 1'b0;
    check("stall_req_ready_busy", 32'(s_req_ready), 32'd0);
    wait_wready("stall_wready");
    drive_beat(32'hE0, 4'hF);
    drive_beat(32'hE1, 4'hF);
    wdata = 32'hDEADBEEF;
    stall_ok = 1'b1;
    repeat (3) begin
      if (!s_wready || s_req_ready) stall_ok = 1'b0;
      step();
    end
    check("stall_wready_held", 32'(stall_ok), 32'd1);
    drive_beat(32'hE2, 4'hF);
    drive_beat(32'hE3, 4'hF);
    check("stall_wready_end", 32'(s_wready), 32'd0);
    check("stall_req_ready_done_state", 32'(s_req_ready), 32'd0);
    step();
    check("stall_done", 32'(s_done), 32'd1);
    check("stall_req_ready_idle", 32'(s_req_ready), 32'd1);
    rd_collect("rdstall");
    check("stall_beats", rn, 4);
    for (int i = 0; i < 4; i++) check("stall_data", rbuf[i], 32'hE0 + 32'(i));
    check("stall_done_at", done_at, 7);

    // Reset mid-burst
    wr_burst(8'h40, 4'd4, 32'h01, 4'hF, 4, "wr40pre");
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h40; req_len = 4'd4;
    step();
    req_valid = 1'b0;
    wait_wready("rstmid_wready");
    drive_beat(32'hF0, 4'hF);
    drive_beat(32'hF1, 4'hF);
    wvalid = 1'b1;
    wdata  = 32'hF2;
    rst    = 1'b0;
    exp_rd = 0;
    exp_wr = 0;
    #1;
    check("rstmid_busy",      32'(s_busy),      32'd0);
    check("rstmid_wready",    32'(s_wready),    32'd0);
    check("rstmid_done",      32'(s_done),      32'd0);
    check("rstmid_req_ready", 32'(s_req_ready), 32'd1);
    step();
    rst    = 1'b1;
    wvalid = 1'b0;
    step();
    check("rstmid_no_done", 32'(s_done), 32'd0);
    rd_burst(8'h40, 4'd4, "rd40");
    check("rstmid_w0", rbuf[0], 32'hF0);
    check("rstmid_w1", rbuf[1], 32'hF1);
    check("rstmid_w2", rbuf[2], 32'h03);
    check("rstmid_w3", rbuf[3], 32'h04);

`ifdef BURST_MEM_ACCESS_CNT_EN
    check("cnt2_rd", rd_beats2, exp_rd);
    check("cnt2_wr", wr_beats2, exp_wr);
`endif

    // LATENCY=0 instance
    sel = 1'b1;
    step();
    wr_burst(8'h03, 4'd3, 32'h70, 4'hF, 3, "l0wr");
    rd_burst(8'h03, 4'd3, "l0rd");
    check("l0_first_lat", first_lat, 1);
    check("l0_beats", rn, 3);
    for (int i = 0; i < 3; i++) check("l0_data", rbuf[i], 32'h70 + 32'(i));
    check("l0_done_at", done_at, 4);
`ifdef BURST_MEM_ACCESS_CNT_EN
    check("cnt0_rd", rd_beats0, 32'd3);
    check("cnt0_wr", wr_beats0, 32'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
